// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC instruction control unit.
// Accepts {op, x, y, z} instruction words over a valid/ready handshake and
// drives register selects, ALU op, immediate and the write strobe.
// Optional feature macro: CONTROL_FAULT_EN (invalid opcodes trap to FAULT and
// decoded mnemonics are printed in simulation). Undefined: invalid opcodes
// retire as nop and fault/fault_op are tied to 0.
module control_unit #(
  parameter int b        = 8,
  parameter int op_b     = 4,
  parameter int sel_b    = 4,
  parameter int alu_op_b = 3,
  parameter int cnt_b    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      instr_valid,
  input  logic [op_b+3*sel_b-1:0]   instr,
  output logic                      instr_ready,
  input  logic                      exec_stall,
  output logic [sel_b-1:0]          x_sel,
  output logic [sel_b-1:0]          y_sel,
  output logic [sel_b-1:0]          z_sel,
  output logic [b-1:0]              imm,
  output logic                      imm_sel,
  output logic [alu_op_b-1:0]       alu_op,
  output logic                      reg_we,
  output logic                      halted,
  output logic                      fault,
  output logic [op_b-1:0]           fault_op,
  output logic [cnt_b-1:0]          retired
);

  localparam int iw = op_b + 3*sel_b;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  state_t state, next_state;

  logic [iw-1:0]        instr_q;
  logic [op_b-1:0]      f_op;
  logic [sel_b-1:0]     f_x, f_y, f_z;
  logic [2*sel_b-1:0]   f_yz;

  // Decoder results, registered into the select outputs on leaving DECODE
  logic                 load_sel;
  logic                 retire;
  logic [sel_b-1:0]     dec_y, dec_z;
  logic                 dec_imm_sel;
  logic [alu_op_b-1:0]  dec_alu;
`ifdef CONTROL_FAULT_EN
  logic                 enter_fault;
`endif

  assign f_op = instr_q[iw-1 -: op_b];
  assign f_x  = instr_q[3*sel_b-1 -: sel_b];
  assign f_y  = instr_q[2*sel_b-1 -: sel_b];
  assign f_z  = instr_q[sel_b-1:0];
  assign f_yz = instr_q[2*sel_b-1:0];

  assign instr_ready = (state == S_FETCH);
  assign reg_we      = (state == S_EXEC);
  assign halted      = (state == S_HALT);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next-state logic and instruction decode
  always_comb begin
    next_state  = state;
    load_sel    = 1'b0;
    retire      = 1'b0;
    dec_y       = f_y;
    dec_z       = f_z;
    dec_imm_sel = 1'b0;
    dec_alu     = '0;
`ifdef CONTROL_FAULT_EN
    enter_fault = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        if (instr_valid) next_state = S_DECODE;
      end
      S_DECODE: begin
        case (f_op)
          op_b'(0): begin retire = 1'b1; next_state = S_FETCH; end
          op_b'(1): begin retire = 1'b1; next_state = S_HALT; end
          op_b'(2): begin load_sel = 1'b1; dec_alu = alu_op_b'(2); dec_imm_sel = 1'b1; end
          op_b'(3): begin load_sel = 1'b1; dec_alu = alu_op_b'(2); dec_z = f_y; end
          op_b'(4): begin load_sel = 1'b1; dec_alu = alu_op_b'(0); end
          op_b'(5): begin load_sel = 1'b1; dec_alu = alu_op_b'(0); dec_y = f_x; dec_imm_sel = 1'b1; end
          op_b'(6): begin load_sel = 1'b1; dec_alu = alu_op_b'(1); end
          op_b'(7): begin load_sel = 1'b1; dec_alu = alu_op_b'(1); dec_y = f_x; dec_imm_sel = 1'b1; end
          op_b'(8): begin load_sel = 1'b1; dec_alu = alu_op_b'(3); end
          op_b'(9): begin load_sel = 1'b1; dec_alu = alu_op_b'(4); end
          op_b'(10): begin load_sel = 1'b1; dec_alu = alu_op_b'(5); end
          default: begin
`ifdef CONTROL_FAULT_EN
            enter_fault = 1'b1;
            next_state  = S_FAULT;
`else
            retire      = 1'b1;
            next_state  = S_FETCH;
`endif
          end
        endcase
        if (load_sel) next_state = S_EXEC;
      end
      S_EXEC: begin
        if (!exec_stall) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_HALT:  next_state = S_HALT;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_FETCH;
    endcase
  end

  // Instruction capture, select/op registers and retired counter
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= '0;
      x_sel   <= '0;
      y_sel   <= '0;
      z_sel   <= '0;
      imm     <= '0;
      imm_sel <= 1'b0;
      alu_op  <= '0;
      retired <= '0;
    end else begin
      if (state == S_FETCH && instr_valid) instr_q <= instr;
      if (load_sel) begin
        x_sel   <= f_x;
        y_sel   <= dec_y;
        z_sel   <= dec_z;
        imm     <= b'(f_yz);
        imm_sel <= dec_imm_sel;
        alu_op  <= dec_alu;
      end
      if (retire) retired <= retired + cnt_b'(1);
    end
  end

`ifdef CONTROL_FAULT_EN
  assign fault = (state == S_FAULT);

  // Latch the offending opcode on entry to FAULT
  always_ff @(posedge clock) begin
    if (reset)            fault_op <= '0;
    else if (enter_fault) fault_op <= f_op;
  end

`ifndef SYNTHESIS
  // Trace each decoded opcode mnemonic
  always_ff @(posedge clock) begin
    if (!reset && state == S_DECODE) begin
      case (f_op)
        op_b'(0):  $display("control_unit: nop");
        op_b'(1):  $display("control_unit: halt");
        op_b'(2):  $display("control_unit: set");
        op_b'(3):  $display("control_unit: copy");
        op_b'(4):  $display("control_unit: addr");
        op_b'(5):  $display("control_unit: addv");
        op_b'(6):  $display("control_unit: subr");
        op_b'(7):  $display("control_unit: subv");
        op_b'(8):  $display("control_unit: and");
        op_b'(9):  $display("control_unit: or");
        op_b'(10): $display("control_unit: xor");
        default:   $display("control_unit: invalid opcode %0d", f_op);
      endcase
    end
  end
`endif
`else
  assign fault    = 1'b0;
  assign fault_op = '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit. A second instance with a 2-bit
// retired counter shares all inputs to observe counter wrap-around.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        exec_stall;

  logic        instr_ready, reg_we, halted, fault, imm_sel;
  logic [3:0]  x_sel, y_sel, z_sel, fault_op;
  logic [7:0]  imm;
  logic [2:0]  alu_op;
  logic [15:0] retired;

  logic        instr_ready2, reg_we2, halted2, fault2, imm_sel2;
  logic [3:0]  x_sel2, y_sel2, z_sel2, fault_op2;
  logic [7:0]  imm2;
  logic [2:0]  alu_op2;
  logic [1:0]  retired2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .exec_stall(exec_stall),
    .x_sel(x_sel), .y_sel(y_sel), .z_sel(z_sel), .imm(imm), .imm_sel(imm_sel),
    .alu_op(alu_op), .reg_we(reg_we), .halted(halted), .fault(fault),
    .fault_op(fault_op), .retired(retired)
  );

  control_unit #(.cnt_b(2)) dut2 (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready2), .exec_stall(exec_stall),
    .x_sel(x_sel2), .y_sel(y_sel2), .z_sel(z_sel2), .imm(imm2), .imm_sel(imm_sel2),
    .alu_op(alu_op2), .reg_we(reg_we2), .halted(halted2), .fault(fault2),
    .fault_op(fault_op2), .retired(retired2)
  );

  function automatic logic [15:0] mk(input int op, input int x, input int y, input int z);
    logic [3:0] o, xx, yy, zz;
    o = 4'(op); xx = 4'(x); yy = 4'(y); zz = 4'(z);
    return {o, xx, yy, zz};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one instruction in FETCH and let it be accepted (ends in DECODE)
  task automatic issue(input logic [15:0] w);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; exec_stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_ready",   32'(instr_ready), 1);
    chk("rst_we",      32'(reg_we), 0);
    chk("rst_halted",  32'(halted), 0);
    chk("rst_fault",   32'(fault), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_xsel",    32'(x_sel), 0);
    chk("rst_aluop",   32'(alu_op), 0);

    // No valid: FETCH holds
    tick();
    chk("idle_ready", 32'(instr_ready), 1);

    // set x=3 imm=0x5A
    issue(mk(2, 3, 5, 10));
    chk("set_dec_ready", 32'(instr_ready), 0);
    chk("set_dec_we",    32'(reg_we), 0);
    tick();
    chk("set_we",      32'(reg_we), 1);
    chk("set_xsel",    32'(x_sel), 3);
    chk("set_imm",     32'(imm), 32'h5A);
    chk("set_aluop",   32'(alu_op), 2);
    chk("set_immsel",  32'(imm_sel), 1);
    chk("set_ret_mid", 32'(retired), 0);
    tick();
    chk("set_ready",   32'(instr_ready), 1);
    chk("set_we_off",  32'(reg_we), 0);
    chk("set_retired", 32'(retired), 1);
    chk("set_xhold",   32'(x_sel), 3);

    // subv x=7 imm=0x01 with 3 stall cycles
    exec_stall = 1'b1;
    issue(mk(7, 7, 0, 1));
    tick();
    chk("subv_we1",    32'(reg_we), 1);
    chk("subv_ysel",   32'(y_sel), 7);
    chk("subv_aluop",  32'(alu_op), 1);
    chk("subv_immsel", 32'(imm_sel), 1);
    chk("subv_imm",    32'(imm), 1);
    tick();
    chk("subv_we2",    32'(reg_we), 1);
    tick();
    chk("subv_we3",    32'(reg_we), 1);
    chk("subv_ret_st", 32'(retired), 1);
    tick();
    chk("subv_we4",    32'(reg_we), 1);
    exec_stall = 1'b0;
    tick();
    chk("subv_we_off", 32'(reg_we), 0);
    chk("subv_ready",  32'(instr_ready), 1);
    chk("subv_retired", 32'(retired), 2);

    // copy x=1 y=2 z=9: z_sel takes y field
    issue(mk(3, 1, 2, 9));
    tick();
    chk("copy_zsel",   32'(z_sel), 2);
    chk("copy_ysel",   32'(y_sel), 2);
    chk("copy_aluop",  32'(alu_op), 2);
    chk("copy_immsel", 32'(imm_sel), 0);
    tick();

    // xor x=4 y=5 z=6
    issue(mk(10, 4, 5, 6));
    tick();
    chk("xor_aluop", 32'(alu_op), 5);
    chk("xor_zsel",  32'(z_sel), 6);
    tick();
    chk("xor_retired", 32'(retired), 4);

    // Invalid opcode 12
    issue(mk(12, 0, 0, 0));
    tick();
`ifdef CONTROL_FAULT_EN
    chk("inv_fault",   32'(fault), 1);
    chk("inv_faultop", 32'(fault_op), 12);
    chk("inv_ready",   32'(instr_ready), 0);
    chk("inv_retired", 32'(retired), 4);
`else
    chk("inv_fault",   32'(fault), 0);
    chk("inv_faultop", 32'(fault_op), 0);
    chk("inv_ready",   32'(instr_ready), 1);
    chk("inv_retired", 32'(retired), 5);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("inv_rst_fault", 32'(fault), 0);

    // halt, then valid is ignored until reset
    issue(mk(1, 0, 0, 0));
    tick();
    chk("halt_halted",  32'(halted), 1);
    chk("halt_ready",   32'(instr_ready), 0);
    chk("halt_retired", 32'(retired), 1);
    instr = mk(2, 1, 1, 1);
    instr_valid = 1'b1;
    tick(); tick(); tick();
    chk("halt_hold",    32'(halted), 1);
    chk("halt_we",      32'(reg_we), 0);
    chk("halt_ret_hold", 32'(retired), 1);
    instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_rst_ready",   32'(instr_ready), 1);
    chk("halt_rst_halted",  32'(halted), 0);
    chk("halt_rst_retired", 32'(retired), 0);

    // Reset during a stalled EXEC
    exec_stall = 1'b1;
    issue(mk(4, 2, 3, 4));
    tick();
    chk("mid_we",    32'(reg_we), 1);
    chk("mid_aluop", 32'(alu_op), 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exec_stall = 1'b0;
    chk("mid_rst_we",      32'(reg_we), 0);
    chk("mid_rst_ready",   32'(instr_ready), 1);
    chk("mid_rst_retired", 32'(retired), 0);

    // Five nops: 2-cycle each, narrow counter wraps 1,2,3,0,1
    issue(mk(0, 0, 0, 0));
    chk("nop_dec_ready", 32'(instr_ready), 0);
    tick();
    chk("nop1_ret2", 32'(retired2), 1);
    chk("nop1_ret",  32'(retired), 1);
    chk("nop1_we",   32'(reg_we), 0);
    issue(mk(0, 0, 0, 0)); tick();
    chk("nop2_ret2", 32'(retired2), 2);
    issue(mk(0, 0, 0, 0)); tick();
    chk("nop3_ret2", 32'(retired2), 3);
    issue(mk(0, 0, 0, 0)); tick();
    chk("nop4_ret2", 32'(retired2), 0);
    issue(mk(0, 0, 0, 0)); tick();
    chk("nop5_ret2", 32'(retired2), 1);
    chk("nop5_ret",  32'(retired), 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle instruction control unit for the 8-bit datapath; parametrised successor to the single-cycle opcode decoder. Accepts instruction words from fetch over a valid/ready handshake and runs a FETCH/DECODE/EXEC state machine. Drives register selects, ALU op, immediate and write strobe to the register file and ALU. Adds logic ops, halt/fault states, a stall input and a retired-instruction counter.

## Interface
- `b`, 8: data width.
- `op_b`, 4: opcode field width.
- `sel_b`, 4: register-select field width.
- `alu_op_b`, 3: ALU op width.
- `cnt_b`, 16: retired-counter width.
- Derived `iw = op_b + 3*sel_b`, the instruction width. Layout is `{op, x, y, z}`, with `op` in the MSBs.
- `clock`, in, 1: the single clock. Everything is sampled on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `instr_valid`, in, 1: fetch has an instruction.
- `instr`, in, `iw`: the instruction word.
- `instr_ready`, out, 1: high only in FETCH.
- `exec_stall`, in, 1: datapath busy; holds EXEC.
- `x_sel`, out, `sel_b`: destination register.
- `y_sel`, out, `sel_b`: ALU operand A source.
- `z_sel`, out, `sel_b`: ALU operand B source.
- `imm`, out, `b`: immediate `{y,z}`, zero-extended or truncated to `b`.
- `imm_sel`, out, 1: operand B comes from `imm`.
- `alu_op`, out, `alu_op_b`: 0 add, 1 sub, 2 pass-B, 3 and, 4 or, 5 xor.
- `reg_we`, out, 1: register write strobe.
- `halted`, out, 1: HALT state.
- `fault`, out, 1: FAULT state.
- `fault_op`, out, `op_b`: opcode that caused the fault.
- `retired`, out, `cnt_b`: retired-instruction count.

## Operation
- All outputs are registered or decoded from state.
- Reset values:
  - State is FETCH, so `instr_ready` is 1.
  - All other outputs are 0, including `retired` and `fault_op`.
- FETCH: when `instr_valid` and `instr_ready` are both high, capture `instr` and go to DECODE.
- DECODE: register `x_sel`, `y_sel`, `z_sel`, `imm`, `imm_sel` and `alu_op`, then branch on opcode:
  - 0 nop: retire, go to FETCH.
  - 1 halt: retire, go to HALT.
  - 2 set: x ← imm. `alu_op` pass-B, `imm_sel` 1.
  - 3 copy: x ← y. `alu_op` pass-B, `z_sel` = y field, `imm_sel` 0.
  - 4 addr: x ← y+z.
  - 5 addv: x ← x+imm. `y_sel` = x field, `imm_sel` 1.
  - 6 subr: x ← y−z.
  - 7 subv: x ← x−imm. `y_sel` = x field, `imm_sel` 1.
  - 8 and, 9 or, 10 xor: x ← y op z.
  - Opcodes 2–10 go to EXEC.
  - Opcodes 11 and up are invalid. See Configuration.
- EXEC:
  - `reg_we` = 1 and all select/op outputs are held.
  - `exec_stall` = 1: stay in EXEC and keep `reg_we` high. The datapath commits only on the cycle stall is low.
  - `exec_stall` = 0: retire, go to FETCH.
- HALT: `halted` = 1, `instr_ready` = 0. Only `reset` exits.
- FAULT: `fault` = 1, `instr_ready` = 0, `fault_op` is latched. Only `reset` exits. Faulting instructions are not retired.
- Retire means `retired` increments by 1, modulo 2^`cnt_b` (wraps to 0).
- Selects keep their last value outside EXEC. `reg_we` is 0 in every state except EXEC.

## Timing
- Handshake is accepted at edge N. DECODE runs in cycle N+1. `reg_we` is first high in cycle N+2.
- Peak throughput is one ALU instruction per 3 cycles. A nop takes 2 cycles.
- `retired` updates on the edge that leaves DECODE (nop, halt) or EXEC (all others).
- `instr_ready` drops the cycle after acceptance. There is no back-to-back acceptance.
- `reset` wins over everything in any state, including mid-EXEC and mid-stall: the in-flight instruction is discarded and `reg_we` is 0 the next cycle.
- `instr_valid` is ignored outside FETCH.

## Configuration
- `CONTROL_FAULT_EN` defined:
  - Invalid opcodes go to FAULT as described.
  - Each decoded opcode's mnemonic is also printed with `$display` (simulation only).
- Macro undefined:
  - Invalid opcodes are treated as nop: retired, back to FETCH.
  - `fault` and `fault_op` are tied to 0.
  - No display.

## Test plan
- Reset, then `set` x=3 imm=0x5A → in cycle N+2: `reg_we`=1, `x_sel`=3, `imm`=0x5A, `alu_op`=2, `imm_sel`=1. In FETCH at N+3. `retired`=1.
- `subv` x=7 imm=0x01 with `exec_stall` high for 3 cycles → `reg_we` high 4 cycles, `y_sel`=7, `alu_op`=1. `retired` increments once.
- `halt` → `halted`=1 and `instr_ready`=0 indefinitely. `instr_valid` is ignored until `reset`, which returns to FETCH with `retired`=0.
- Opcode 12 with macro defined → `fault`=1, `fault_op`=12, `retired` unchanged. Without the macro → treated as nop, `retired`+1.
- `cnt_b`=2, 5 nops → `retired` sequence 1, 2, 3, 0, 1.
- `reset` asserted during EXEC → next cycle `reg_we`=0, `instr_ready`=1.
